const_frame_buf: RTL and testbench

- Ping-pong symbol buffer directly downstream of the constellation encoder.
- Captures each (carrier number, X, Y) point as the encoder strobes it out, in tone order, into the write bank.
- At end of DMT symbol, swaps banks and streams the completed symbol to the IFFT input stage in ascending carrier order, 0..NCARR-1, under valid/ready handshake.
- Carriers not written in a symbol are emitted as (0,0) and flagged unused.

---
 rtl/const_frame_buf.sv | 130 +++++++++++++
 tb/tb_const_frame_buf.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/const_frame_buf.sv
// Ping-pong constellation buffer: captures encoder points per carrier, streams each symbol 0..NCARR-1.
// First point 2 cycles after sym_end; input has no backpressure (overflow is sticky); output holds under !out_ready_i.
module const_frame_buf #(
   parameter int CNUMW  = 8,
   parameter int CONSTW = 9,
   parameter int NCARR  = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     xy_valid_i,
   input  logic [CNUMW-1:0]         carrier_num_i,
   input  logic signed [CONSTW-1:0] x_i,
   input  logic signed [CONSTW-1:0] y_i,
   input  logic                     sym_end_i,
   output logic                     in_ready_o,
   output logic                     ovf_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [CNUMW-1:0]         out_idx_o,
   output logic signed [CONSTW-1:0] out_x_o,
   output logic signed [CONSTW-1:0] out_y_o,
   output logic                     out_used_o,
   output logic                     out_last_o
);
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] STREAM = 1'b1;
   localparam logic [CNUMW-1:0] LAST_IDX = CNUMW'(NCARR - 1);

   logic [2*CONSTW-1:0] mem [0:2*NCARR-1];
   logic [NCARR-1:0]    used [0:1];
   logic [1:0]          full, full_nxt;
   logic                wb, rb, fb;
   logic [0:0]          state;
   logic [CNUMW-1:0]    fidx;
   logic                s1_vld, s1_used, s1_last;
   logic [CNUMW-1:0]    s1_idx;
   logic [2*CONSTW-1:0] rd_q;
   logic                wr_acc, out_adv, s1_adv, fetch_en, release_rb;

   assign in_ready_o = !full[wb];
   assign wr_acc     = xy_valid_i && in_ready_o;
   assign out_adv    = !out_valid_o || out_ready_i;
   assign s1_adv     = !s1_vld || out_adv;
   // fb runs ahead of rb so the next symbol is fetched while the previous one drains
   assign fetch_en   = s1_adv && ((state == STREAM) || full[fb]);
   assign release_rb = out_valid_o && out_ready_i && out_last_o;

   always_comb begin
      full_nxt = full;
      if (release_rb)
         full_nxt[rb] = 1'b0;
      if (wr_acc && sym_end_i)
         full_nxt[wb] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[{wb, carrier_num_i}] <= {x_i, y_i};
      if (fetch_en)
         rd_q <= mem[{fb, fidx}];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb      <= 1'b0;
         rb      <= 1'b0;
         fb      <= 1'b0;
         full    <= 2'b00;
         used[0] <= '0;
         used[1] <= '0;
         ovf_o   <= 1'b0;
         state   <= IDLE;
         fidx    <= '0;
         s1_vld  <= 1'b0;
         s1_idx  <= '0;
         s1_used <= 1'b0;
         s1_last <= 1'b0;
      end else begin
         full <= full_nxt;
         if (release_rb) begin
            used[rb] <= '0;
            rb       <= ~rb;
         end
         if (wr_acc) begin
            used[wb][carrier_num_i] <= 1'b1;
            if (sym_end_i)
               wb <= ~wb;
         end
         if (xy_valid_i && !in_ready_o)
            ovf_o <= 1'b1;

         if (fetch_en) begin
            fidx    <= fidx + 1'b1;
            s1_vld  <= 1'b1;
            s1_idx  <= fidx;
            s1_used <= used[fb][fidx];
            s1_last <= (fidx == LAST_IDX);
            if (fidx == LAST_IDX) begin
               fb    <= ~fb;
               state <= IDLE;
            end else begin
               state <= STREAM;
            end
         end else if (out_adv) begin
            s1_vld <= 1'b0;
         end
      end
   end

   // unused carriers are masked to zero here, so RAM contents never need clearing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_o <= 1'b0;
         out_idx_o   <= '0;
         out_x_o     <= '0;
         out_y_o     <= '0;
         out_used_o  <= 1'b0;
         out_last_o  <= 1'b0;
      end else if (out_adv) begin
         out_valid_o <= s1_vld;
         if (s1_vld) begin
            out_idx_o  <= s1_idx;
            out_x_o    <= s1_used ? $signed(rd_q[2*CONSTW-1:CONSTW]) : '0;
            out_y_o    <= s1_used ? $signed(rd_q[CONSTW-1:0]) : '0;
            out_used_o <= s1_used;
            out_last_o <= s1_last;
         end
      end
   end
endmodule

// File: tb/tb_const_frame_buf.sv
// Directed bench for const_frame_buf: latency, ordering, masking, overflow, stall stability, reset.
module tb_const_frame_buf;
   logic              clk = 1'b0;
   logic              reset;
   logic              xy_valid_i;
   logic [7:0]        carrier_num_i;
   logic signed [8:0] x_i, y_i;
   logic              sym_end_i;
   logic              in_ready_o, ovf_o, out_valid_o, out_ready_i;
   logic [7:0]        out_idx_o;
   logic signed [8:0] out_x_o, out_y_o;
   logic              out_used_o, out_last_o;

   int checks = 0;
   int failures = 0;

   // stream entries packed as {idx, x, y, used, last}
   logic [27:0] cap [0:511];
   logic [8:0]  ex_x [0:511];
   logic [8:0]  ex_y [0:511];
   logic        ex_used [0:511];
   int          cap_n, hold_errs, gaps;
   bit          timeout;

   always #5 clk = ~clk;

   const_frame_buf #(.CNUMW(8), .CONSTW(9), .NCARR(256)) dut (
      .clk(clk), .reset(reset), .xy_valid_i(xy_valid_i), .carrier_num_i(carrier_num_i),
      .x_i(x_i), .y_i(y_i), .sym_end_i(sym_end_i), .in_ready_o(in_ready_o), .ovf_o(ovf_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_idx_o(out_idx_o),
      .out_x_o(out_x_o), .out_y_o(out_y_o), .out_used_o(out_used_o), .out_last_o(out_last_o)
   );

   task automatic put(input int c, input int x, input int y, input bit e);
      xy_valid_i    = 1'b1;
      carrier_num_i = c[7:0];
      x_i           = x[8:0];
      y_i           = y[8:0];
      sym_end_i     = e;
      @(posedge clk); #1;
      xy_valid_i = 1'b0;
      sym_end_i  = 1'b0;
   endtask

   task automatic exp_clear();
      for (int i = 0; i < 512; i++) begin
         ex_x[i] = '0; ex_y[i] = '0; ex_used[i] = 1'b0;
      end
   endtask

   task automatic exp_set(input int s, input int c, input int x, input int y);
      ex_x[s*256+c]    = x[8:0];
      ex_y[s*256+c]    = y[8:0];
      ex_used[s*256+c] = 1'b1;
   endtask

   // Collects n handshakes; records stall instability and valid gaps after the first capture.
   task automatic drain(input int n, input bit rnd, input int budget);
      logic [28:0] snap, cur;
      bit          prev_hold;
      int          cyc;
      cap_n = 0; hold_errs = 0; gaps = 0; timeout = 0; cyc = 0; prev_hold = 0; snap = '0;
      while (cap_n < n) begin
         if (cyc == budget) begin
            timeout = 1;
            break;
         end
         cur = {out_valid_o, out_idx_o, out_x_o, out_y_o, out_used_o, out_last_o};
         if (prev_hold && cur !== snap) hold_errs++;
         if (!out_valid_o && cap_n > 0) gaps++;
         out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid_o && out_ready_i) begin
            cap[cap_n] = cur[27:0];
            cap_n++;
         end
         prev_hold = out_valid_o && !out_ready_i;
         snap = cur;
         @(posedge clk); #1;
         cyc++;
      end
      out_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; xy_valid_i = 1'b0; carrier_num_i = '0; x_i = '0; y_i = '0;
      sym_end_i = 1'b0; out_ready_i = 1'b0;
      #12;
      checks++;
      if ({out_valid_o, out_idx_o, out_x_o, out_y_o, out_used_o, out_last_o} !== 29'd0) begin
         failures++; $display("FAIL reset_outs: got %h want 0", {out_valid_o, out_idx_o, out_x_o, out_y_o, out_used_o, out_last_o});
      end
      checks++;
      if ({in_ready_o, ovf_o} !== 2'b10) begin
         failures++; $display("FAIL reset_in_ready_ovf: got %b want 10", {in_ready_o, ovf_o});
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      exp_clear();
      exp_set(0, 3, 5, -3);
      exp_set(0, 7, -1, 1);
      out_ready_i = 1'b1;
      put(3, 5, -3, 0);
      put(7, -1, 1, 1);
      checks++;
      if (out_valid_o !== 1'b0) begin failures++; $display("FAIL basic_lat0: got %b want 0", out_valid_o); end
      @(posedge clk); #1;
      checks++;
      if (out_valid_o !== 1'b0) begin failures++; $display("FAIL basic_lat1: got %b want 0", out_valid_o); end
      @(posedge clk); #1;
      checks++;
      if (out_valid_o !== 1'b1) begin failures++; $display("FAIL basic_lat2: got %b want 1", out_valid_o); end
      drain(256, 0, 400);
      checks++;
      if (timeout) begin failures++; $display("FAIL basic_timeout: got %0d points want 256", cap_n); end
      for (int i = 0; i < cap_n; i++) begin
         checks++;
         if (cap[i] !== {8'(i % 256), ex_x[i], ex_y[i], ex_used[i], (i % 256 == 255)}) begin
            failures++; $display("FAIL basic_pt%0d: got %h want %h", i, cap[i], {8'(i % 256), ex_x[i], ex_y[i], ex_used[i], (i % 256 == 255)});
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_clear();
      out_ready_i = 1'b0;
      for (int c = 0; c < 256; c++) begin
         exp_set(0, c, c - 128, 100 - c);
         put(c, c - 128, 100 - c, c == 255);
      end
      for (int c = 255; c >= 0; c--) begin
         exp_set(1, c, 127 - c, c / 2 - 64);
         put(c, 127 - c, c / 2 - 64, c == 0);
      end
      checks++;
      if ({in_ready_o, ovf_o} !== 2'b00) begin failures++; $display("FAIL b2b_full: got rdy,ovf=%b want 00", {in_ready_o, ovf_o}); end
      put(5, 99, 99, 1);
      checks++;
      if ({in_ready_o, ovf_o} !== 2'b01) begin failures++; $display("FAIL b2b_ovf: got rdy,ovf=%b want 01", {in_ready_o, ovf_o}); end
      drain(512, 0, 700);
      checks++;
      if (timeout) begin failures++; $display("FAIL b2b_timeout: got %0d points want 512", cap_n); end
      checks++;
      if (gaps !== 0) begin failures++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
      for (int i = 0; i < cap_n; i++) begin
         checks++;
         if (cap[i] !== {8'(i % 256), ex_x[i], ex_y[i], ex_used[i], (i % 256 == 255)}) begin
            failures++; $display("FAIL b2b_pt%0d: got %h want %h", i, cap[i], {8'(i % 256), ex_x[i], ex_y[i], ex_used[i], (i % 256 == 255)});
         end
      end
      checks++;
      if ({in_ready_o, ovf_o} !== 2'b11) begin failures++; $display("FAIL b2b_after: got rdy,ovf=%b want 11", {in_ready_o, ovf_o}); end
   endtask

   task automatic test_random_ready();
      exp_clear();
      exp_set(0, 0, -256, 255); exp_set(0, 128, 100, -100); exp_set(0, 255, -5, -6);
      exp_set(1, 1, 11, 12); exp_set(1, 254, -13, 14);
      put(0, -256, 255, 0); put(128, 100, -100, 0); put(255, -5, -6, 1);
      put(1, 11, 12, 0); put(254, -13, 14, 1);
      drain(512, 1, 3000);
      checks++;
      if (timeout) begin failures++; $display("FAIL rnd_timeout: got %0d points want 512", cap_n); end
      checks++;
      if (hold_errs !== 0) begin failures++; $display("FAIL rnd_hold: got %0d unstable stalls want 0", hold_errs); end
      for (int i = 0; i < cap_n; i++) begin
         checks++;
         if (cap[i] !== {8'(i % 256), ex_x[i], ex_y[i], ex_used[i], (i % 256 == 255)}) begin
            failures++; $display("FAIL rnd_pt%0d: got %h want %h", i, cap[i], {8'(i % 256), ex_x[i], ex_y[i], ex_used[i], (i % 256 == 255)});
         end
      end
   endtask

   task automatic test_duplicate();
      exp_clear();
      exp_set(0, 10, -7, 4); exp_set(0, 20, 3, 3);
      exp_set(1, 20, -2, 6);
      put(10, 1, 2, 0); put(10, -7, 4, 0); put(20, 3, 3, 1);
      put(20, -2, 6, 1);
      drain(512, 0, 700);
      checks++;
      if (timeout) begin failures++; $display("FAIL dup_timeout: got %0d points want 512", cap_n); end
      for (int i = 0; i < cap_n; i++) begin
         checks++;
         if (cap[i] !== {8'(i % 256), ex_x[i], ex_y[i], ex_used[i], (i % 256 == 255)}) begin
            failures++; $display("FAIL dup_pt%0d: got %h want %h", i, cap[i], {8'(i % 256), ex_x[i], ex_y[i], ex_used[i], (i % 256 == 255)});
         end
      end
      // third symbol lands in the first symbol's bank: carriers 10/20 must read unused
      exp_clear();
      exp_set(0, 30, 1, 1);
      put(30, 1, 1, 1);
      drain(256, 0, 400);
      checks++;
      if (timeout) begin failures++; $display("FAIL dup3_timeout: got %0d points want 256", cap_n); end
      for (int i = 0; i < cap_n; i++) begin
         checks++;
         if (cap[i] !== {8'(i), ex_x[i], ex_y[i], ex_used[i], (i == 255)}) begin
            failures++; $display("FAIL dup3_pt%0d: got %h want %h", i, cap[i], {8'(i), ex_x[i], ex_y[i], ex_used[i], (i == 255)});
         end
      end
   endtask

   task automatic test_first_point_end();
      exp_clear();
      exp_set(0, 0, 9, -9);
      put(0, 9, -9, 1);
      drain(256, 0, 400);
      checks++;
      if (timeout) begin failures++; $display("FAIL first_timeout: got %0d points want 256", cap_n); end
      for (int i = 0; i < cap_n; i++) begin
         checks++;
         if (cap[i] !== {8'(i), ex_x[i], ex_y[i], ex_used[i], (i == 255)}) begin
            failures++; $display("FAIL first_pt%0d: got %h want %h", i, cap[i], {8'(i), ex_x[i], ex_y[i], ex_used[i], (i == 255)});
         end
      end
   endtask

   task automatic test_reset_mid();
      put(100, 50, -50, 1);
      drain(100, 0, 300);
      checks++;
      if ({out_valid_o, out_idx_o} !== {1'b1, 8'd100}) begin
         failures++; $display("FAIL mid_pos: got v,idx=%b,%0d want 1,100", out_valid_o, out_idx_o);
      end
      put(5, 1, 1, 0);
      checks++;
      if (ovf_o !== 1'b1) begin failures++; $display("FAIL mid_ovf_pre: got %b want 1", ovf_o); end
      reset = 1'b0;
      #1;
      checks++;
      if ({out_valid_o, out_idx_o, out_x_o, out_y_o, out_used_o, out_last_o} !== 29'd0) begin
         failures++; $display("FAIL mid_reset_outs: got %h want 0", {out_valid_o, out_idx_o, out_x_o, out_y_o, out_used_o, out_last_o});
      end
      checks++;
      if ({in_ready_o, ovf_o} !== 2'b10) begin failures++; $display("FAIL mid_reset_rdy_ovf: got %b want 10", {in_ready_o, ovf_o}); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      exp_clear();
      exp_set(0, 3, 7, 7);
      put(3, 7, 7, 1);
      drain(256, 0, 400);
      checks++;
      if (timeout) begin failures++; $display("FAIL mid_timeout: got %0d points want 256", cap_n); end
      for (int i = 0; i < cap_n; i++) begin
         checks++;
         if (cap[i] !== {8'(i), ex_x[i], ex_y[i], ex_used[i], (i == 255)}) begin
            failures++; $display("FAIL mid_pt%0d: got %h want %h", i, cap[i], {8'(i), ex_x[i], ex_y[i], ex_used[i], (i == 255)});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_random_ready();
      test_duplicate();
      test_first_point_end();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
